// File: rtl/neuron_spike_queue.sv
// Spike queue stage: registers potential write-back, buffers spiking neuron indices in a FWFT FIFO,
// and tracks timestep completion. Optional macro SPIKE_QUEUE_TSTAMP_EN tags each entry with an 8-bit timestep.
module neuron_spike_queue #(
  parameter int NUM_NEURONS = 256,
  parameter int IDX_W       = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            tick_i,
  input  logic                            eval_valid_i,
  input  logic [IDX_W-1:0]                neuron_idx_i,
  input  logic                            spike_i,
  input  logic [7:0]                      new_potential_i,
  output logic                            pot_we_o,
  output logic [IDX_W-1:0]                pot_addr_o,
  output logic [7:0]                      pot_data_o,
  output logic                            spike_valid_o,
  input  logic                            spike_ready_i,
  output logic [IDX_W-1:0]                spike_idx_o,
`ifdef SPIKE_QUEUE_TSTAMP_EN
  output logic [7:0]                      spike_ts_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic [CNT_W-1:0]                spike_count_o,
  output logic                            overflow_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef SPIKE_QUEUE_TSTAMP_EN
  localparam int EW = IDX_W + 8;
`else
  localparam int EW = IDX_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  spk_cnt_q, spk_cnt_d, spk_base;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              pot_we_q;
  logic [IDX_W-1:0]  pot_addr_q;
  logic [7:0]        pot_data_q;

  logic              empty, full, push_req, push_ok, pop, drop, last_eval;
  logic [EW-1:0]     entry, head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign push_req  = eval_valid_i & spike_i;
  // Pop requires a non-empty FIFO, so an empty-FIFO push+pop lands the push only.
  assign pop       = ~empty & spike_ready_i;
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign last_eval = eval_valid_i & (neuron_idx_i == IDX_W'(NUM_NEURONS - 1));

`ifdef SPIKE_QUEUE_TSTAMP_EN
  logic [7:0] ts_q, ts_d;
  assign ts_d  = tick_i ? ts_q + 8'd1 : ts_q;
  assign entry = {ts_d, neuron_idx_i};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ts_q <= '0;
    else          ts_q <= ts_d;
  end

  assign spike_ts_o = empty ? '0 : head[EW-1:IDX_W];
`else
  assign entry = neuron_idx_i;
`endif

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Tick clears first, so a same-cycle push is counted from zero.
  always_comb begin
    spk_base  = tick_i ? '0 : spk_cnt_q;
    spk_cnt_d = spk_base;
    if (push_ok && (spk_base != '1)) spk_cnt_d = spk_base + 1'b1;
    ovf_d = (tick_i ? 1'b0 : ovf_q) | drop;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (tick_i) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (last_eval) state_d = S_DRAIN;
        S_DRAIN: begin
          if (empty) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spk_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      pot_we_q   <= 1'b0;
      pot_addr_q <= '0;
      pot_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      spk_cnt_q <= spk_cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      pot_we_q  <= eval_valid_i;
      if (eval_valid_i) begin
        pot_addr_q <= neuron_idx_i;
        pot_data_q <= new_potential_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry;
  end

  assign pot_we_o      = pot_we_q;
  assign pot_addr_o    = pot_addr_q;
  assign pot_data_o    = pot_data_q;
  assign spike_valid_o = ~empty;
  assign spike_idx_o   = empty ? '0 : head[IDX_W-1:0];
  assign fifo_count_o  = count_q;
  assign spike_count_o = spk_cnt_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_neuron_spike_queue.sv
// Scoreboard bench for neuron_spike_queue: stimulus pushes expected write-backs and spike pops,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_neuron_spike_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, ev = 1'b0, spk = 1'b0, rdy = 1'b0;
  logic [7:0] idx = '0, pot = '0;

  logic       pot_we, sv, ovf, busy, done;
  logic [7:0] pot_addr, pot_data, sidx;
  logic [4:0] fcount;
  logic [15:0] scount;
`ifdef SPIKE_QUEUE_TSTAMP_EN
  logic [7:0] sts;
`endif

  int tests = 0, fails = 0, done_cnt = 0, d0 = 0, me = 0;
  int wb_q[$];
  int sp_q[$];

  always #5 clk = ~clk;

  neuron_spike_queue #(.NUM_NEURONS(256), .IDX_W(8), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .tick_i(tick), .eval_valid_i(ev),
    .neuron_idx_i(idx), .spike_i(spk), .new_potential_i(pot),
    .pot_we_o(pot_we), .pot_addr_o(pot_addr), .pot_data_o(pot_data),
    .spike_valid_o(sv), .spike_ready_i(rdy), .spike_idx_o(sidx),
`ifdef SPIKE_QUEUE_TSTAMP_EN
    .spike_ts_o(sts),
`endif
    .fifo_count_o(fcount), .spike_count_o(scount), .overflow_o(ovf),
    .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit t, input bit v, input bit s, input int i, input bit acc);
    tick = t; ev = v; spk = s;
    idx  = i[7:0];
    pot  = 8'(i * 3 + 7);
    if (v) wb_q.push_back(i * 256 + int'(pot));
    if (v && s && acc) sp_q.push_back(i);
    step();
    tick = 1'b0; ev = 1'b0; spk = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && (sp_q.size() != 0 || sv); k++) step();
    chk("drain_bound", sp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pot_we) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          me = wb_q.pop_front();
          chk("wb_addr", int'(pot_addr), me / 256);
          chk("wb_data", int'(pot_data), me % 256);
        end
      end
      if (sv && rdy) begin
        if (sp_q.size() == 0) chk("pop_unexpected", int'(sidx), -1);
        else begin
          me = sp_q.pop_front();
          chk("pop_idx", int'(sidx), me);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_while_valid", int'(sv), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pot_we", int'(pot_we), 0);
    chk("rst_valid", int'(sv), 0);
    chk("rst_fcount", int'(fcount), 0);
    chk("rst_scount", int'(scount), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    step();

    // Full timestep, spikes on 5, 77, 255, router always ready
    rdy = 1'b1;
    drive(1, 0, 0, 0, 0);
    chk("t1_busy", int'(busy), 1);
    for (int i = 0; i < 256; i++) drive(0, 1, (i == 5 || i == 77 || i == 255), i, 1);
    d0 = done_cnt;
    for (int k = 0; k < 50 && busy; k++) step();
    step();
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_scount", int'(scount), 3);
    chk("t1_ovf", int'(ovf), 0);
    chk("t1_sp_left", sp_q.size(), 0);
    chk("t1_wb_left", wb_q.size(), 0);

    // Overflow: 20 spikes with router stalled
    rdy = 1'b0;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 1, i, i < 16);
    step();
    chk("t2_fcount", int'(fcount), 16);
    chk("t2_ovf", int'(ovf), 1);
    chk("t2_scount", int'(scount), 16);
    chk("t2_head", int'(sidx), 0);

    // New timestep keeps FIFO, then full + pop + push of 42
    drive(1, 0, 0, 0, 0);
    chk("t3_ovf_clr", int'(ovf), 0);
    chk("t3_scount_clr", int'(scount), 0);
    chk("t3_fcount_kept", int'(fcount), 16);
    rdy = 1'b1;
    drive(0, 1, 1, 42, 1);
    rdy = 1'b0;
    chk("t3_fcount_full_pp", int'(fcount), 16);
    chk("t3_ovf_full_pp", int'(ovf), 0);
    rdy = 1'b1;
    wait_drain();
    chk("t3_fcount_empty", int'(fcount), 0);

    // Empty on DRAIN entry: one DRAIN cycle then done
    rdy = 1'b0;
    drive(0, 1, 0, 255, 1);
    chk("t4_drain_busy", int'(busy), 1);
    chk("t4_drain_nodone", int'(done), 0);
    step();
    chk("t4_done", int'(done), 1);
    chk("t4_idle", int'(busy), 0);
    step();
    chk("t4_done_single", int'(done), 0);

    // Tick mid-COLLECT keeps entries and clears counters
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) drive(0, 1, 1, i, 1);
    chk("t5_scount", int'(scount), 3);
    chk("t5_fcount", int'(fcount), 3);
    drive(1, 0, 0, 0, 0);
    chk("t5_scount_clr", int'(scount), 0);
    chk("t5_ovf_clr", int'(ovf), 0);
    chk("t5_fcount_kept", int'(fcount), 3);
    chk("t5_busy", int'(busy), 1);
    drive(1, 1, 1, 4, 1);
    chk("t5_tick_push_cnt", int'(scount), 1);
    chk("t5_fcount4", int'(fcount), 4);

    // Reset mid-DRAIN with 5 entries queued
    drive(0, 1, 1, 10, 1);
    drive(0, 1, 0, 255, 1);
    step();
    chk("t6_drain_busy", int'(busy), 1);
    chk("t6_fcount5", int'(fcount), 5);
    d0 = done_cnt;
    rst = 1'b1;
    sp_q.delete();
    wb_q.delete();
    step();
    chk("t6_rst_valid", int'(sv), 0);
    chk("t6_rst_fcount", int'(fcount), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_scount", int'(scount), 0);
    rst = 1'b0;
    step();
    step();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_idle", int'(busy), 0);

`ifdef SPIKE_QUEUE_TSTAMP_EN
    rdy = 1'b0;
    for (int t = 0; t < 3; t++) drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 9, 1);
    chk("ts_valid", int'(sv), 1);
    chk("ts_idx", int'(sidx), 9);
    chk("ts_value", int'(sts), 3);
    rdy = 1'b1;
    wait_drain();
`endif

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/neuron_spike_queue.md
Name: neuron_spike_queue

Overview:
- Downstream stage of the per-neuron integrate/threshold datapath; consumes one evaluation result per cycle (neuron index, spike bit, new potential).
- Registers the potential write-back toward the potential store and queues spiking neuron indices in a FIFO for the spike router.
- Tracks the end of each timestep, counts spikes, and signals `done` once the timestep's spikes have drained.

Parameters:
- NUM_NEURONS, 256, neurons evaluated per timestep; the last index is NUM_NEURONS-1.
- IDX_W, 8, neuron index width.
- FIFO_DEPTH, 16, spike FIFO entries; must be a power of 2.
- CNT_W, 16, spike counter width.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- tick_i  in  1  timestep start pulse
- eval_valid_i  in  1  evaluation result valid this cycle
- neuron_idx_i  in  IDX_W  index of the evaluated neuron
- spike_i  in  1  spike bit from the neuron datapath
- new_potential_i  in  8  updated potential from the neuron datapath
- pot_we_o  out  1  potential write strobe
- pot_addr_o  out  IDX_W  potential write address
- pot_data_o  out  8  potential write data
- spike_valid_o  out  1  FIFO not empty
- spike_ready_i  in  1  router accepts the head entry
- spike_idx_o  out  IDX_W  head neuron index
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy
- spike_count_o  out  CNT_W  spikes accepted this timestep
- overflow_o  out  1  sticky: a spike was dropped
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at end of timestep

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0, FIFO empty, state IDLE.
  - Applies mid-operation too: queued spikes are discarded.
- Write-back path:
  - When eval_valid_i=1, next cycle pot_we_o=1, pot_addr_o=neuron_idx_i, pot_data_o=new_potential_i.
  - Latency 1; one write per valid; independent of state and FIFO fullness.
  - pot_addr_o/pot_data_o hold their last values when pot_we_o=0.
- Push: eval_valid_i & spike_i.
  - Not full → enqueue neuron_idx_i and increment spike_count_o; the counter saturates at all-ones.
  - Full and no pop this cycle → drop the entry, set overflow_o; spike_count_o not incremented.
  - Full with a simultaneous pop → push accepted, count unchanged.
- Pop (FWFT):
  - spike_valid_o = !empty; spike_idx_o = head entry, valid combinationally with spike_valid_o.
  - Pop when spike_valid_o & spike_ready_i.
  - spike_idx_o is stable while spike_valid_o=1 and spike_ready_i=0.
- Empty FIFO with simultaneous push and pop: the push lands and the pop is ignored; valid rises the next cycle. There is no bypass.
- Read and write pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: on tick_i → COLLECT; clear spike_count_o and overflow_o.
  - COLLECT: on eval_valid_i with neuron_idx_i == NUM_NEURONS-1 → DRAIN. That last evaluation's spike is still pushed.
  - DRAIN: when the FIFO is empty (after pops) → IDLE, with done_o=1 for that single cycle. If the FIFO is already empty on entry, DRAIN lasts exactly one cycle before done_o.
  - tick_i in COLLECT or DRAIN: restart to COLLECT, clear spike_count_o and overflow_o; keep FIFO contents; no done_o.
- eval_valid_i in IDLE:
  - Write-back still occurs.
  - Spikes are still queued and counted.
  - No state change.
- tick_i and eval_valid_i in the same cycle: the counter clear applies first, then that cycle's push counts as 1.

Optional Feature:
- Macro: SPIKE_QUEUE_TSTAMP_EN.
- Defined:
  - An 8-bit timestep counter increments on every tick_i and wraps 255→0.
  - Each FIFO entry stores {tstamp, idx}.
  - Adds port spike_ts_o (out, 8), valid with spike_idx_o.
  - The counter resets to 0.
- Undefined: no counter, no port, entries are IDX_W bits only.

Test Plan:
- Reset then tick_i; evals idx 0..255 with spikes on idx 5, 77, 255, spike_ready_i=1 → pot_we_o 256 pulses, each at +1 cycle with matching addr/data; spike_idx_o sequence 5, 77, 255; spike_count_o=3; done_o one pulse after 255 drains.
- spike_ready_i=0, 20 consecutive spiking evals idx 0..19 → fifo_count_o=16, overflow_o=1, spike_count_o=16; release ready → pops 0..15 in order.
- FIFO full with spike_valid_o & spike_ready_i high plus a push of idx 42 in the same cycle → fifo_count_o stays 16, overflow_o stays 0, 42 is the last entry popped.
- Assert wb_rst_i mid-DRAIN with 5 entries queued → next cycle spike_valid_o=0, fifo_count_o=0, busy_o=0, no done_o.
- tick_i during COLLECT with 3 entries queued → spike_count_o=0, overflow_o=0, entries retained; busy_o stays 1.
- SPIKE_QUEUE_TSTAMP_EN defined: 3 ticks, spike on idx 9 in the 3rd timestep → spike_ts_o=3 with spike_idx_o=9.
